// File: rtl/mrd_rdx5_gather_if.sv
// mrd_rdx5_gather_if: sample stream in, 5-wide group out for the radix-5 gather stage
//   master: drives in_val/in_sop/din_*, observes out_val/err_sop/dout_*
//   slave : the gather block itself
interface mrd_rdx5_gather_if #(parameter int wDataInOut = 30);
  logic in_val;
  logic in_sop;
  logic signed [wDataInOut-1:0] din_real;
  logic signed [wDataInOut-1:0] din_imag;
  logic out_val;
  logic err_sop;
  logic signed [wDataInOut-1:0] dout_real [0:4];
  logic signed [wDataInOut-1:0] dout_imag [0:4];
  modport master (output in_val, in_sop, din_real, din_imag,
                  input  out_val, err_sop, dout_real, dout_imag);
  modport slave  (input  in_val, in_sop, din_real, din_imag,
                  output out_val, err_sop, dout_real, dout_imag);
endinterface

// File: rtl/mrd_rdx5_gather.sv
// mrd_rdx5_gather: collects 5 consecutive complex samples into one parallel group
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of mrd_rdx5_gather_if (in_val/in_sop/din_* in; out_val/err_sop/dout_* out)
module mrd_rdx5_gather #(
  parameter int wDataInOut = 30,
  parameter bit SOP_ALIGN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  mrd_rdx5_gather_if.slave   bus
);
  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_COLL = 1'b1;
  localparam logic [0:0] S_RST  = SOP_ALIGN ? S_WAIT : S_COLL;
  typedef logic signed [wDataInOut-1:0] w_t;
  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  w_t slot_r_q [0:3], slot_r_d [0:3];
  w_t slot_i_q [0:3], slot_i_d [0:3];
  w_t dout_r_q [0:4], dout_r_d [0:4];
  w_t dout_i_q [0:4], dout_i_d [0:4];
  logic out_val_q, out_val_d;
  logic err_sop_q, err_sop_d;
  // Slot 4 is never stored: the 5th sample goes straight to dout, so the
  // next group can start filling slot 0 on the following cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_r_d  = slot_r_q;
    slot_i_d  = slot_i_q;
    dout_r_d  = dout_r_q;
    dout_i_d  = dout_i_q;
    out_val_d = 1'b0;
    err_sop_d = 1'b0;
    if (bus.in_val) begin
      if (state_q == S_WAIT) begin
        if (bus.in_sop) begin
          slot_r_d[0] = bus.din_real;
          slot_i_d[0] = bus.din_imag;
          cnt_d       = 3'd1;
          state_d     = S_COLL;
        end
      end else if (bus.in_sop) begin
        err_sop_d   = cnt_q != 3'd0;
        slot_r_d[0] = bus.din_real;
        slot_i_d[0] = bus.din_imag;
        cnt_d       = 3'd1;
      end else if (cnt_q == 3'd4) begin
        for (int k = 0; k < 4; k++) begin
          dout_r_d[k] = slot_r_q[k];
          dout_i_d[k] = slot_i_q[k];
        end
        dout_r_d[4] = bus.din_real;
        dout_i_d[4] = bus.din_imag;
        out_val_d   = 1'b1;
        cnt_d       = 3'd0;
      end else begin
        slot_r_d[cnt_q[1:0]] = bus.din_real;
        slot_i_d[cnt_q[1:0]] = bus.din_imag;
        cnt_d                = cnt_q + 3'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RST;
      cnt_q     <= '0;
      slot_r_q  <= '{default: '0};
      slot_i_q  <= '{default: '0};
      dout_r_q  <= '{default: '0};
      dout_i_q  <= '{default: '0};
      out_val_q <= 1'b0;
      err_sop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_r_q  <= slot_r_d;
      slot_i_q  <= slot_i_d;
      dout_r_q  <= dout_r_d;
      dout_i_q  <= dout_i_d;
      out_val_q <= out_val_d;
      err_sop_q <= err_sop_d;
    end
  end
  assign bus.out_val = out_val_q;
  assign bus.err_sop = err_sop_q;
  for (genvar g = 0; g < 5; g++) begin : g_out
    assign bus.dout_real[g] = dout_r_q[g];
    assign bus.dout_imag[g] = dout_i_q[g];
  end
endmodule
